// File: rtl/alu_exec_stage.sv
// alu_exec_stage: RISC-V execute stage. Computes the ALU result for an
// accepted operation and buffers it in a 2-entry in-order FIFO with
// valid/ready handshakes on both sides and a synchronous flush.
module alu_exec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_control,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOP = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } entry_t;

  entry_t          mem_q [0:1];
  entry_t          mem_d [0:1];
  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_rw;
  logic            alu_ill;
  entry_t          new_e;
  entry_t          head_e;
  logic            tail;
  logic            push, pop;

  // ALU result and effective write enable for the incoming operation
  always_comb begin
    alu_res = '0;
    alu_rw  = in_reg_write;
    alu_ill = 1'b0;
    case (in_alu_control)
      ALU_AND: alu_res = in_op_a & in_op_b;
      ALU_OR:  alu_res = in_op_a | in_op_b;
      ALU_ADD: alu_res = in_op_a + in_op_b;
      ALU_SUB: alu_res = in_op_a - in_op_b;
      ALU_SLT: alu_res[0] = ($signed(in_op_a) < $signed(in_op_b));
      ALU_NOP: alu_rw = 1'b0;
      default: begin
        alu_rw  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
    new_e.result    = alu_res;
    new_e.zero      = (alu_res == '0);
    new_e.rd        = in_rd;
    new_e.reg_write = alu_rw;
    new_e.illegal   = alu_ill;
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  // Free slot is the one after the head while fewer than two entries are held
  assign tail      = head_q ^ count_q[0];

  // Next-state for the FIFO: flush overrides push and pop
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      count_d = '0;
    end else begin
      if (push) mem_d[tail] = new_e;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      mem_q   <= mem_d;
    end
  end

  // Head entry presented downstream, zeroed when nothing is valid
  always_comb begin
    head_e        = mem_q[head_q];
    out_result    = '0;
    out_zero      = 1'b0;
    out_rd        = '0;
    out_reg_write = 1'b0;
    out_illegal   = 1'b0;
    if (out_valid) begin
      out_result    = head_e.result;
      out_zero      = head_e.zero;
      out_rd        = head_e.rd;
      out_reg_write = head_e.reg_write;
      out_illegal   = head_e.illegal;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus random traffic
// against a queue-based reference of the buffered results.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_control = 4'hF;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(in_alu_control), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t mq[$];
  int   checks = 0;
  int   failures = 0;
  logic last_push = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the operation table
  function automatic exp_t ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input logic rw);
    exp_t   e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.rd = rd; e.rw = rw; e.ill = 1'b0; e.result = '0;
    case (c)
      4'h0: e.result = a & b;
      4'h1: e.result = a | b;
      4'h2: e.result = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'h6: e.result = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'h7: e.result = (sa < sb) ? 32'd1 : 32'd0;
      4'hF: e.rw = 1'b0;
      default: begin e.rw = 1'b0; e.ill = 1'b1; end
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  task automatic set_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_alu_control = c; in_op_a = a; in_op_b = b; in_rd = rd; in_reg_write = rw;
  endtask

  // Check outputs against the model, advance the model, then step one clock
  task automatic cycle();
    exp_t h;
    logic push, pop;
    h = (mq.size() != 0) ? mq[0] : '0;
    check("in_ready", 64'(in_ready), 64'(mq.size() != 2));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("out_head", 64'({out_result, out_zero, out_rd, out_reg_write, out_illegal}), 64'(h));
    push = in_valid && (mq.size() != 2) && !flush;
    pop  = (mq.size() != 0) && out_ready && !flush;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(ref_alu(in_alu_control, in_op_a, in_op_b, in_rd, in_reg_write));
    end
    last_push = push;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 10 && mq.size() != 0; n++) cycle();
    check("drain_done", 64'(mq.size()), 64'd0);
  endtask

  logic [3:0]  sw_code [5];
  logic [31:0] sw_a [5], sw_b [5], sw_exp [5];
  logic [3:0]  rcodes [8];

  initial begin
    sw_code[0] = 4'h2; sw_a[0] = 32'h7FFF_FFFF; sw_b[0] = 32'h1;     sw_exp[0] = 32'h8000_0000;
    sw_code[1] = 4'h6; sw_a[1] = 32'd5;         sw_b[1] = 32'd5;     sw_exp[1] = 32'h0;
    sw_code[2] = 4'h7; sw_a[2] = 32'hFFFF_FFFF; sw_b[2] = 32'h1;     sw_exp[2] = 32'h1;
    sw_code[3] = 4'h0; sw_a[3] = 32'hF0F0;      sw_b[3] = 32'h0FF0;  sw_exp[3] = 32'h00F0;
    sw_code[4] = 4'h1; sw_a[4] = 32'hF000;      sw_b[4] = 32'h000F;  sw_exp[4] = 32'hF00F;
    rcodes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF, 4'h5, 4'hA};

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    cycle();
    cycle();

    // Function sweep, back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(sw_code[i], sw_a[i], sw_b[i], 5'(i + 1), 1'b1);
      cycle();
      check("sweep_valid", 64'(out_valid), 64'd1);
      check("sweep_result", 64'(out_result), 64'(sw_exp[i]));
      check("sweep_zero", 64'(out_zero), 64'(sw_exp[i] == 0));
    end

    // NOP and undefined code
    set_op(4'hF, 32'h1234, 32'h5678, 5'd3, 1'b1);
    cycle();
    check("nop_res_rw_ill", 64'({out_result, out_reg_write, out_illegal}), 64'h0);
    set_op(4'h5, 32'h1234, 32'h5678, 5'd4, 1'b1);
    cycle();
    check("bad_res_rw_ill", 64'({out_result, out_reg_write, out_illegal}), 64'h1);
    drain();

    // Back-pressure: A, B accepted, C held until a slot frees
    out_ready = 1'b0;
    set_op(4'h2, 32'd10, 32'd1, 5'd10, 1'b1); cycle();
    set_op(4'h2, 32'd20, 32'd2, 5'd11, 1'b1); cycle();
    check("bp_full", 64'(in_ready), 64'd0);
    set_op(4'h2, 32'd30, 32'd3, 5'd12, 1'b1); cycle();
    check("bp_c_blocked", 64'(last_push), 64'd0);
    out_ready = 1'b1;
    cycle();
    check("bp_c_blocked_pop", 64'(last_push), 64'd0);
    check("bp_head_b", 64'(out_result), 64'd22);
    cycle();
    check("bp_c_accepted", 64'(last_push), 64'd1);
    check("bp_head_c", 64'(out_result), 64'd33);
    drain();

    // Steady push+pop at occupancy 1
    out_ready = 1'b0;
    set_op(4'h1, 32'h1, 32'h2, 5'd1, 1'b1); cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_op(rcodes[$urandom_range(0, 4)], $urandom, $urandom, 5'($urandom), 1'($urandom));
      cycle();
      check("pp_count1", 64'({out_valid, in_ready}), 64'h3);
    end
    drain();

    // Flush while full with an incoming op
    out_ready = 1'b0;
    set_op(4'h2, 32'd1, 32'd1, 5'd1, 1'b1); cycle();
    set_op(4'h2, 32'd2, 32'd2, 5'd2, 1'b1); cycle();
    flush = 1'b1;
    set_op(4'h2, 32'd3, 32'd3, 5'd3, 1'b1);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = $urandom;
      set_op(rcodes[$urandom_range(0, 7)], a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
             5'($urandom), 1'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;

    // Asynchronous reset with entries buffered
    out_ready = 1'b0;
    set_op(4'h2, 32'd7, 32'd8, 5'd5, 1'b1); cycle();
    set_op(4'h2, 32'd9, 32'd8, 5'd6, 1'b1); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_outs", 64'({out_result, out_zero, out_rd, out_reg_write, out_illegal}), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    cycle();
    cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
